text_render: RTL
================

# text_render

Pixel pipeline that turns tile coordinates into RGB output for a character display. It takes the tile number and in-tile pixel position from the tile-decode stage. It reads the character code from an external text RAM and the glyph row from an external font ROM, then selects the glyph bit and emits a foreground or background colour. Display-enable and sync are delayed to stay aligned with the pixel, and the result drives the video output stage.

## Interface
- TILE_WIDTH, 16: glyph width in pixels
- TILE_HEIGHT, 24: glyph height in rows
- TILE_NUM_BITS, 12: width of tile number (text RAM address)
- CHAR_BITS, 8: character code width
- COLOUR_BITS, 24: pixel colour width
- BLINK_FRAMES, 30: frames per cursor blink half-period (cursor build only)
- FONT_ADDR_BITS, $clog2((1<<CHAR_BITS)*TILE_HEIGHT): font ROM address width
- in_clk  in  1  pixel clock
- in_rst_n  in  1  asynchronous, active-low reset
- in_tile_num  in  TILE_NUM_BITS  tile index of current pixel
- in_tile_pix_x  in  $clog2(TILE_WIDTH)  column inside tile
- in_tile_pix_y  in  $clog2(TILE_HEIGHT)  row inside tile
- in_de  in  1  display enable (visible pixel)
- in_hsync, in_vsync  in  1 each  sync, passed through
- in_fg, in_bg  in  COLOUR_BITS each  foreground/background colour, sampled in stage 3
- in_cursor_num  in  TILE_NUM_BITS  cursor tile (cursor build only)
- out_text_addr  out  TILE_NUM_BITS  text RAM read address
- in_text_data  in  CHAR_BITS  text RAM data, valid 1 cycle after address
- out_font_addr  out  FONT_ADDR_BITS  font ROM read address
- in_font_data  in  TILE_WIDTH  glyph row, valid 1 cycle after address; MSB is leftmost pixel
- out_pixel  out  COLOUR_BITS  output colour
- out_de, out_hsync, out_vsync  out  1 each  delayed enable/sync

## Operation
- Stage 0 (combinational): out_text_addr = in_tile_num. Register pix_x, pix_y, de, hsync, vsync, tile_num into stage-1 regs.
- Stage 1: out_font_addr = in_text_data * TILE_HEIGHT + pix_y_s1, computed at FONT_ADDR_BITS width with no truncation of valid codes. Register pix_x, de, syncs, and the cursor flag into stage-2 regs.
- Stage 2: bit = in_font_data[TILE_WIDTH-1 - pix_x_s2]. Register bit, de, syncs, and cursor flag into stage-3 regs.
- Stage 3 (output regs): out_pixel = de ? (bit ? in_fg : in_bg) : 0. Syncs and de are copied.
- pix_x >= TILE_WIDTH cannot occur. If it is driven anyway, the selected bit is treated as 0.
- The pipeline runs every cycle; there is no stall and no handshake. External memories must have a fixed read latency of 1 cycle.
- Colour inputs are sampled in the same cycle they are used and are not pipelined.

## Timing
- Latency is 3 in_clk cycles from in_de/in_hsync/in_vsync/in_tile_* to out_de/out_hsync/out_vsync/out_pixel. Throughput is 1 pixel per cycle.
- Reset (in_rst_n=0, asynchronous): all pipeline regs clear; out_pixel=0, out_de=0, out_hsync=0, out_vsync=0. In the cursor build, the blink counter=0 and phase=0.
- The first 3 cycles after reset release emit the reset values, then valid pipelined data.
- Reset asserted mid-line: outputs clear immediately, without waiting for a clock edge. There is no resynchronisation to the line; the upstream timing generator restarts the frame.
- When out_de=0, out_pixel is forced to 0 regardless of glyph data.

## Configuration
- TEXT_RENDER_CURSOR_EN defined:
  - A frame counter increments on each rising edge of in_vsync.
  - When the counter reaches BLINK_FRAMES-1, it wraps to 0 and the blink phase toggles.
  - Stage 1 flags cursor = (tile_num_s1 == in_cursor_num), and the flag is carried with the pixel.
  - In stage 3, if cursor && phase, the pixel is inverted: bit=1 gives in_bg, bit=0 gives in_fg.
- TEXT_RENDER_CURSOR_EN undefined:
  - in_cursor_num is unused and the counter logic is absent.
  - out_pixel depends only on the glyph bit.

## Test plan
- Reset held, then released with in_de=1 constant: out_pixel=0 and out_de=0 for 3 cycles, then out_de=1 on cycle 3.
- Text RAM returns char 0x41, font row for (0x41*24+5) = 0x8001, tile_pix_y=5, pix_x swept 0..15, in_fg=0xFFFFFF, in_bg=0x000000: out_pixel is 0xFFFFFF at pix_x 0 and 15 and 0 elsewhere, each 3 cycles after its input.
- in_hsync pulse of 96 cycles, with in_vsync toggling independently: both appear on outputs unchanged in width, delayed exactly 3 cycles.
- in_de=0 while the font row is 0xFFFF: out_pixel=0 throughout.
- Cursor build, in_cursor_num=7, BLINK_FRAMES=2, glyph all zeros: tile 7 shows in_bg in frames 0–1 and in_fg in frames 2–3; other tiles always show in_bg.
- in_rst_n pulsed low mid-line for a half cycle: outputs go to 0 asynchronously, and in the cursor build the blink phase returns to 0.

Source files
------------

// File: rtl/text_render_if.sv
// text_render_if
// Pixel stream and external memory signals of the text renderer.
// The upstream tile-decode stage, the text RAM and the font ROM sit on the
// master side; text_render sits on the slave side.
//
// Signals (directions seen from the slave / renderer):
//   in_tile_num    in   tile index of current pixel (text RAM address)
//   in_tile_pix_x  in   column inside tile
//   in_tile_pix_y  in   row inside tile
//   in_de          in   display enable
//   in_hsync       in   horizontal sync
//   in_vsync       in   vertical sync
//   in_fg, in_bg   in   foreground / background colour
//   in_cursor_num  in   cursor tile (only used by the cursor build)
//   out_text_addr  out  text RAM read address
//   in_text_data   in   text RAM data, one cycle after the address
//   out_font_addr  out  font ROM read address
//   in_font_data   in   glyph row, one cycle after the address, MSB leftmost
//   out_pixel      out  output colour
//   out_de         out  delayed display enable
//   out_hsync      out  delayed horizontal sync
//   out_vsync      out  delayed vertical sync
interface text_render_if #(
  parameter int TILE_WIDTH     = 16,
  parameter int TILE_HEIGHT    = 24,
  parameter int TILE_NUM_BITS  = 12,
  parameter int CHAR_BITS      = 8,
  parameter int COLOUR_BITS    = 24,
  parameter int FONT_ADDR_BITS = $clog2((32'd1 << CHAR_BITS) * TILE_HEIGHT)
);
  localparam int PIX_X_BITS = $clog2(TILE_WIDTH);
  localparam int PIX_Y_BITS = $clog2(TILE_HEIGHT);

  logic [TILE_NUM_BITS-1:0]  in_tile_num;
  logic [PIX_X_BITS-1:0]     in_tile_pix_x;
  logic [PIX_Y_BITS-1:0]     in_tile_pix_y;
  logic                      in_de;
  logic                      in_hsync;
  logic                      in_vsync;
  logic [COLOUR_BITS-1:0]    in_fg;
  logic [COLOUR_BITS-1:0]    in_bg;
  logic [TILE_NUM_BITS-1:0]  in_cursor_num;
  logic [TILE_NUM_BITS-1:0]  out_text_addr;
  logic [CHAR_BITS-1:0]      in_text_data;
  logic [FONT_ADDR_BITS-1:0] out_font_addr;
  logic [TILE_WIDTH-1:0]     in_font_data;
  logic [COLOUR_BITS-1:0]    out_pixel;
  logic                      out_de;
  logic                      out_hsync;
  logic                      out_vsync;

  modport master (
    output in_tile_num, in_tile_pix_x, in_tile_pix_y, in_de, in_hsync, in_vsync,
    output in_fg, in_bg, in_cursor_num, in_text_data, in_font_data,
    input  out_text_addr, out_font_addr, out_pixel, out_de, out_hsync, out_vsync
  );

  modport slave (
    input  in_tile_num, in_tile_pix_x, in_tile_pix_y, in_de, in_hsync, in_vsync,
    input  in_fg, in_bg, in_cursor_num, in_text_data, in_font_data,
    output out_text_addr, out_font_addr, out_pixel, out_de, out_hsync, out_vsync
  );
endinterface

// File: rtl/text_render.sv
// text_render
// Three-stage pixel pipeline for a character display: tile number -> text RAM
// character code -> font ROM glyph row -> glyph bit -> foreground/background
// colour. Enable and syncs travel with the pixel so everything leaves
// together, three in_clk cycles after it entered.
//
// Ports:
//   in_clk    pixel clock
//   in_rst_n  asynchronous active-low reset, clears every pipeline register
//   vid       text_render_if.slave: pixel stream in/out plus text RAM and
//             font ROM address/data (both memories have a 1-cycle read latency)
//
// Build option: define TEXT_RENDER_CURSOR_EN to add a blinking block cursor.
// A frame counter advances on every rising edge of in_vsync; every
// BLINK_FRAMES frames the blink phase toggles, and while the phase is set the
// tile matching in_cursor_num is drawn with fg/bg swapped. Without the macro
// in_cursor_num is ignored and no counter exists.
module text_render #(
  parameter int TILE_WIDTH     = 16,
  parameter int TILE_HEIGHT    = 24,
  parameter int TILE_NUM_BITS  = 12,
  parameter int CHAR_BITS      = 8,
  parameter int COLOUR_BITS    = 24,
  parameter int BLINK_FRAMES   = 30,
  parameter int FONT_ADDR_BITS = $clog2((32'd1 << CHAR_BITS) * TILE_HEIGHT)
) (
  input  logic         in_clk,
  input  logic         in_rst_n,
  text_render_if.slave vid
);

  localparam int PIX_X_BITS = $clog2(TILE_WIDTH);
  localparam int PIX_Y_BITS = $clog2(TILE_HEIGHT);

  // Picks the glyph bit for column x; MSB of the row is the leftmost pixel.
  // Built as a compare-per-column mux so a column outside the glyph
  // selects nothing and yields 0 instead of indexing off the row.
  function automatic logic glyph_bit(
    input logic [TILE_WIDTH-1:0] row,
    input logic [PIX_X_BITS-1:0] x
  );
    logic b;
    b = 1'b0;
    for (int i = 0; i < TILE_WIDTH; i++) begin
      if (int'(x) == (TILE_WIDTH - 1 - i)) begin
        b = row[i];
      end else begin
        b = b;
      end
    end
    return b;
  endfunction

  // Stage 1 registers
  logic [PIX_X_BITS-1:0]     pix_x_s1_r;
  logic [PIX_Y_BITS-1:0]     pix_y_s1_r;
  logic                      de_s1_r;
  logic                      hsync_s1_r;
  logic                      vsync_s1_r;
  logic [TILE_NUM_BITS-1:0]  tile_num_s1_r;

  // Stage 2 registers
  logic [PIX_X_BITS-1:0]     pix_x_s2_r;
  logic                      de_s2_r;
  logic                      hsync_s2_r;
  logic                      vsync_s2_r;

  // Output registers
  logic [COLOUR_BITS-1:0]    pixel_r;
  logic                      de_r;
  logic                      hsync_r;
  logic                      vsync_r;

  logic [FONT_ADDR_BITS-1:0] font_addr_s;
  logic                      glyph_bit_s;
  logic                      invert_s;

  // Stage 0: the text RAM is addressed straight from the incoming tile.
  assign vid.out_text_addr = vid.in_tile_num;

  // Stage 1: each character owns TILE_HEIGHT consecutive font rows. The
  // product is formed at full font-address width so no code is truncated.
  assign font_addr_s = FONT_ADDR_BITS'(vid.in_text_data) * FONT_ADDR_BITS'(TILE_HEIGHT)
                     + FONT_ADDR_BITS'(pix_y_s1_r);
  assign vid.out_font_addr = font_addr_s;

  // Stage 2: glyph row has arrived, pick the pixel's bit.
  assign glyph_bit_s = glyph_bit(vid.in_font_data, pix_x_s2_r);

  // Stage 1 capture: pixel position, timing and tile alongside the RAM read.
  always_ff @(posedge in_clk or negedge in_rst_n) begin
    if (!in_rst_n) begin
      pix_x_s1_r    <= '0;
      pix_y_s1_r    <= '0;
      de_s1_r       <= 1'b0;
      hsync_s1_r    <= 1'b0;
      vsync_s1_r    <= 1'b0;
      tile_num_s1_r <= '0;
    end else begin
      pix_x_s1_r    <= vid.in_tile_pix_x;
      pix_y_s1_r    <= vid.in_tile_pix_y;
      de_s1_r       <= vid.in_de;
      hsync_s1_r    <= vid.in_hsync;
      vsync_s1_r    <= vid.in_vsync;
      tile_num_s1_r <= vid.in_tile_num;
    end
  end

  // Stage 2 capture: column and timing alongside the font ROM read.
  always_ff @(posedge in_clk or negedge in_rst_n) begin
    if (!in_rst_n) begin
      pix_x_s2_r <= '0;
      de_s2_r    <= 1'b0;
      hsync_s2_r <= 1'b0;
      vsync_s2_r <= 1'b0;
    end else begin
      pix_x_s2_r <= pix_x_s1_r;
      de_s2_r    <= de_s1_r;
      hsync_s2_r <= hsync_s1_r;
      vsync_s2_r <= vsync_s1_r;
    end
  end

`ifdef TEXT_RENDER_CURSOR_EN
  localparam int BLINK_BITS = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  logic [BLINK_BITS-1:0] frame_cnt_r;
  logic                  phase_r;
  logic                  vsync_prev_r;
  logic                  cursor_s1_s;
  logic                  cursor_s2_r;
  logic                  vsync_rise_s;

  assign cursor_s1_s  = (tile_num_s1_r == vid.in_cursor_num);
  assign vsync_rise_s = vid.in_vsync & ~vsync_prev_r;
  assign invert_s     = cursor_s2_r & phase_r;

  // Blink timebase: count frames on vsync rising edges, toggle phase on wrap.
  always_ff @(posedge in_clk or negedge in_rst_n) begin
    if (!in_rst_n) begin
      frame_cnt_r  <= '0;
      phase_r      <= 1'b0;
      vsync_prev_r <= 1'b0;
    end else begin
      vsync_prev_r <= vid.in_vsync;
      if (vsync_rise_s) begin
        if (frame_cnt_r == BLINK_BITS'(BLINK_FRAMES - 1)) begin
          frame_cnt_r <= '0;
          phase_r     <= ~phase_r;
        end else begin
          frame_cnt_r <= frame_cnt_r + BLINK_BITS'(1);
        end
      end else begin
        frame_cnt_r <= frame_cnt_r;
      end
    end
  end

  // Cursor flag travels with its pixel from stage 1 into stage 2.
  always_ff @(posedge in_clk or negedge in_rst_n) begin
    if (!in_rst_n) begin
      cursor_s2_r <= 1'b0;
    end else begin
      cursor_s2_r <= cursor_s1_s;
    end
  end
`else
  localparam int unused_blink_frames_lp = BLINK_FRAMES;

  logic unused_s;

  assign invert_s = 1'b0;
  assign unused_s = ^{vid.in_cursor_num, tile_num_s1_r};
`endif

  // Output stage: colour select (blanked outside the active area) and
  // the final copy of enable and syncs.
  always_ff @(posedge in_clk or negedge in_rst_n) begin
    if (!in_rst_n) begin
      pixel_r <= '0;
      de_r    <= 1'b0;
      hsync_r <= 1'b0;
      vsync_r <= 1'b0;
    end else begin
      de_r    <= de_s2_r;
      hsync_r <= hsync_s2_r;
      vsync_r <= vsync_s2_r;
      if (!de_s2_r) begin
        pixel_r <= '0;
      end else if (glyph_bit_s ^ invert_s) begin
        pixel_r <= vid.in_fg;
      end else begin
        pixel_r <= vid.in_bg;
      end
    end
  end

  assign vid.out_pixel = pixel_r;
  assign vid.out_de    = de_r;
  assign vid.out_hsync = hsync_r;
  assign vid.out_vsync = vsync_r;

endmodule
